// File: rtl/accum_jk_drv.sv
// accum_jk_drv
// Excitation driver for a WIDTH-bit accumulator built from a bank of JK
// flip-flops. An operation (add, sub, clear, load) is accepted over a
// valid/ready handshake, the target value is computed from the fed-back Q
// vector, minimal J/K excitation is driven for exactly one cycle, and the
// read-back is checked one cycle later.
//
// Optional feature: define ACCUM_JK_SATURATE_EN to clamp add-with-carry to
// all-ones and sub-with-borrow to zero. Carry and ovf are still reported.
// Without the macro the result wraps modulo 2^WIDTH.
//
// Ports:
//   clk       system clock, all state updates on posedge
//   rst       synchronous active-high reset (does not touch the JK bank)
//   in_valid  operation request
//   in_ready  high in IDLE only
//   in_op     00 add, 01 sub, 10 clear, 11 load
//   in_data   operand (ignored for clear)
//   q_fb      Q outputs of the JK bank
//   jk_j      J inputs to the JK bank (non-zero only in APPLY)
//   jk_k      K inputs to the JK bank (non-zero only in APPLY)
//   sum       last computed target value
//   carry     carry (add) or borrow (sub) of the last op
//   ovf       sticky overflow, cleared by a clear op or reset
//   done      one-cycle completion pulse
//   err       pulses with done when the read-back differs from the target
module accum_jk_drv #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    APPLY = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] jk_j_q, jk_j_d;
  logic [WIDTH-1:0] jk_k_q, jk_k_d;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] t;
  logic             c;

`ifdef ACCUM_JK_SATURATE_EN
  // Replace the wrapped result by the rail value when the op over/underflowed.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wrapped,
                                                input logic             hit,
                                                input logic [WIDTH-1:0] rail);
    return hit ? rail : wrapped;
  endfunction
`endif

  // The extra top bit of the widened difference is the borrow (d > qs).
  assign add_w = {1'b0, q_fb} + {1'b0, data_q};
  assign sub_w = {1'b0, q_fb} - {1'b0, data_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    jk_j_d  = '0;
    jk_k_d  = '0;
    t       = '0;
    c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          data_d  = in_data;
          state_d = CALC;
        end
      end
      CALC: begin
        unique case (op_q)
          OP_ADD: begin
            c = add_w[WIDTH];
`ifdef ACCUM_JK_SATURATE_EN
            t = saturate(add_w[WIDTH-1:0], c, '1);
`else
            t = add_w[WIDTH-1:0];
`endif
            ovf_d = ovf_q | c;
          end
          OP_SUB: begin
            c = sub_w[WIDTH];
`ifdef ACCUM_JK_SATURATE_EN
            t = saturate(sub_w[WIDTH-1:0], c, '0);
`else
            t = sub_w[WIDTH-1:0];
`endif
            ovf_d = ovf_q | c;
          end
          OP_CLR: begin
            t     = '0;
            ovf_d = 1'b0;
          end
          default: begin
            t = data_q;
          end
        endcase
        sum_d   = t;
        carry_d = c;
        // Minimal excitation: set bits going 0->1, reset bits going 1->0,
        // hold the rest. J and K are never both high.
        jk_j_d  = ~q_fb & t;
        jk_k_d  = q_fb & ~t;
        state_d = APPLY;
      end
      APPLY: begin
        state_d = CHECK;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      jk_j_q  <= '0;
      jk_k_q  <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      jk_j_q  <= jk_j_d;
      jk_k_q  <= jk_k_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    data_q <= data_d;
  end

  assign in_ready = (state_q == IDLE);
  assign jk_j     = jk_j_q;
  assign jk_k     = jk_k_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign ovf      = ovf_q;
  // The bank captured j/k at the end of APPLY, so q_fb in CHECK is the result.
  assign done     = (state_q == CHECK);
  assign err      = done && (q_fb != sum_q);

endmodule

// File: tb/tb_accum_jk_drv.sv
module tb_accum_jk_drv;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_LD  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'b00;
  logic [3:0] in_data = 4'h0;
  logic [3:0] q_fb;
  logic [3:0] jk_j, jk_k, sum;
  logic       carry, ovf, done, err;

  logic [3:0] bank = 4'h0;
  logic       force_en = 1'b0;
  logic       frc_plan = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] d;
    logic       frc;
    logic [3:0] s;
    logic       c;
    logic       o;
    logic [3:0] j;
    logic [3:0] k;
  } vec_t;

  typedef struct {
    logic [3:0] s;
    logic       c;
    logic       o;
    logic       e;
  } sb_t;

  sb_t  sbq[$];
  logic m_ovf = 1'b0;
  vec_t tbl[13];

  always #5 clk = ~clk;

  assign q_fb = force_en ? 4'hE : bank;

  accum_jk_drv #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .q_fb(q_fb), .jk_j(jk_j), .jk_k(jk_k),
    .sum(sum), .carry(carry), .ovf(ovf), .done(done), .err(err)
  );

  // JK flip-flop bank model
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      case ({jk_j[i], jk_k[i]})
        2'b10:   bank[i] <= 1'b1;
        2'b01:   bank[i] <= 1'b0;
        2'b11:   bank[i] <= ~bank[i];
        default: bank[i] <= bank[i];
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model(input logic [1:0] op, input logic [3:0] d, input logic [3:0] qs,
                                input logic ovf_in, output logic [3:0] t, output logic c,
                                output logic o);
    logic [4:0] w;
    t = 4'h0; c = 1'b0; o = ovf_in;
    case (op)
      OP_ADD: begin
        w = {1'b0, qs} + {1'b0, d};
        c = w[4]; t = w[3:0]; o = ovf_in | c;
`ifdef ACCUM_JK_SATURATE_EN
        if (c) t = 4'hF;
`endif
      end
      OP_SUB: begin
        c = (d > qs); t = qs - d; o = ovf_in | c;
`ifdef ACCUM_JK_SATURATE_EN
        if (c) t = 4'h0;
`endif
      end
      OP_CLR: begin t = 4'h0; o = 1'b0; end
      default: t = d;
    endcase
  endfunction

  // Scoreboard push on accept; reset flushes anything in flight
  always @(posedge clk) begin
    sb_t        e;
    logic [3:0] t;
    logic       c, o;
    if (rst) begin
      sbq.delete();
      m_ovf <= 1'b0;
    end else if (in_valid && in_ready) begin
      model(in_op, in_data, bank, m_ovf, t, c, o);
      e.s = t; e.c = c; e.o = o;
      e.e = frc_plan ? (t != 4'hE) : 1'b0;
      sbq.push_back(e);
      m_ovf <= o;
    end
  end

  // Scoreboard pop on done, plus per-cycle excitation legality
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (done) begin
        if (sbq.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_sum", sum, e.s);
          chk("sb_carry", carry, e.c);
          chk("sb_ovf", ovf, e.o);
          chk("sb_err", err, e.e);
        end
      end
      chk("jk_both_high", jk_j & jk_k, 0);
    end
  end

  task automatic wait_ready(input string name);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk(name, in_ready, 1);
  endtask

  task automatic run_op(input vec_t v);
    wait_ready("ready_idle");
    frc_plan = v.frc;
    in_valid = 1'b1; in_op = v.op; in_data = v.d;
    @(negedge clk);
    in_valid = 1'b0; in_data = ~v.d;
    chk("ready_calc", in_ready, 0);
    chk("jk_calc", {jk_j, jk_k}, 0);
    @(negedge clk);
    chk("apply_j", jk_j, v.j);
    chk("apply_k", jk_k, v.k);
    chk("apply_sum", sum, v.s);
    chk("apply_carry", carry, v.c);
    chk("apply_ovf", ovf, v.o);
    chk("ready_apply", in_ready, 0);
    if (v.frc) force_en = 1'b1;
    @(negedge clk);
    chk("check_done", done, 1);
    chk("jk_check", {jk_j, jk_k}, 0);
    chk("ready_check", in_ready, 0);
    @(negedge clk);
    force_en = 1'b0;
    chk("ready_back", in_ready, 1);
    chk("done_low", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    //            op      d     frc   s     c     o     j      k
    tbl[0]  = '{OP_LD,  4'h5, 1'b0, 4'h5, 1'b0, 1'b0, 4'h5, 4'h0};
    tbl[1]  = '{OP_ADD, 4'h3, 1'b0, 4'h8, 1'b0, 1'b0, 4'h8, 4'h5};
    tbl[2]  = '{OP_LD,  4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 4'h7, 4'h0};
`ifdef ACCUM_JK_SATURATE_EN
    tbl[3]  = '{OP_ADD, 4'h1, 1'b0, 4'hF, 1'b1, 1'b1, 4'h0, 4'h0};
    tbl[4]  = '{OP_CLR, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF};
    tbl[5]  = '{OP_SUB, 4'h1, 1'b1, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0};
    tbl[6]  = '{OP_CLR, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0};
`else
    tbl[3]  = '{OP_ADD, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 4'hF};
    tbl[4]  = '{OP_CLR, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0};
    tbl[5]  = '{OP_SUB, 4'h1, 1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 4'h0};
    tbl[6]  = '{OP_CLR, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF};
`endif
    tbl[7]  = '{OP_LD,  4'hA, 1'b0, 4'hA, 1'b0, 1'b0, 4'hA, 4'h0};
    tbl[8]  = '{OP_SUB, 4'h3, 1'b0, 4'h7, 1'b0, 1'b0, 4'h5, 4'h8};
`ifdef ACCUM_JK_SATURATE_EN
    tbl[9]  = '{OP_SUB, 4'hB, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h7};
    tbl[10] = '{OP_LD,  4'h3, 1'b0, 4'h3, 1'b0, 1'b1, 4'h3, 4'h0};
`else
    tbl[9]  = '{OP_SUB, 4'hB, 1'b0, 4'hC, 1'b1, 1'b1, 4'h8, 4'h3};
    tbl[10] = '{OP_LD,  4'h3, 1'b0, 4'h3, 1'b0, 1'b1, 4'h3, 4'hC};
`endif
    tbl[11] = '{OP_ADD, 4'h4, 1'b0, 4'h7, 1'b0, 1'b1, 4'h4, 4'h0};
`ifdef ACCUM_JK_SATURATE_EN
    tbl[12] = '{OP_LD,  4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF};
`else
    tbl[12] = '{OP_LD,  4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h9};
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_jk", {jk_j, jk_k}, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_op(tbl[i]);

    // in_valid held high: one accept every 4 cycles, mid-op data ignored
    wait_ready("ready_hold");
    acc = 0;
    frc_plan = 1'b0;
    in_valid = 1'b1; in_op = OP_ADD;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      in_data = in_ready ? 4'h1 : 4'h9;
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold_accepts", acc, 3);
    chk("hold_sum", sum, 4'hA);
    chk("hold_ready", in_ready, 1);

    // Reset during APPLY aborts the op
    wait_ready("ready_rst");
    in_valid = 1'b1; in_op = OP_ADD; in_data = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef ACCUM_JK_SATURATE_EN
    chk("abort_apply_j", jk_j, 4'h5);
    chk("abort_apply_k", jk_k, 4'h0);
`else
    chk("abort_apply_j", jk_j, 4'h1);
    chk("abort_apply_k", jk_k, 4'h2);
`endif
    chk("abort_apply_ovf", ovf, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_jk", {jk_j, jk_k}, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_ovf", ovf, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end

    run_op(tbl[12]);
    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
